// File: rtl/sindoku_grid_loader.sv
// sindoku_grid_loader
// Writer side of the game core's grid storage. Accepts GRID_N*GRID_N puzzle
// digits followed by GRID_N*GRID_N solution digits on a valid/ready stream,
// validates each digit and emits row-major cell-write strobes.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Start                 begin a load (IDLE only)
//   Ack                   return from DONE/ERR to IDLE
//   in_valid, in_digit    upstream digit stream
//   in_ready              combinational: high in LOADP/LOADS
//   wr_en                 one-cycle write strobe, cycle after acceptance
//   wr_sel                0 puzzle grid, 1 solution grid
//   wr_row, wr_col        target cell
//   wr_data               value to write
//   cell_count            digits accepted in current phase
//   err_code              0 none, 1 bad puzzle, 2 bad solution, 3 mismatch
//   q_Idle..q_Err         one-hot state decode
//
// Optional feature macro: SINDOKU_LOADER_CONSISTENCY_EN
//   When defined, puzzle digits are recorded and each solution digit is
//   checked against a nonzero given at the same cell (err_code 3).

module sindoku_grid_loader #(
  parameter int unsigned GRID_N    = 9,
  parameter int unsigned DIGIT_W   = 5,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] in_digit,
  output logic               in_ready,
  output logic               wr_en,
  output logic               wr_sel,
  output logic [3:0]         wr_row,
  output logic [3:0]         wr_col,
  output logic [DIGIT_W-1:0] wr_data,
  output logic [7:0]         cell_count,
  output logic [1:0]         err_code,
  output logic               q_Idle,
  output logic               q_LoadP,
  output logic               q_LoadS,
  output logic               q_Done,
  output logic               q_Err
);

  localparam int unsigned CELLS   = GRID_N * GRID_N;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned STATE_W = 5;

  localparam logic [STATE_W-1:0] S_IDLE  = 5'b00001;
  localparam logic [STATE_W-1:0] S_LOADP = 5'b00010;
  localparam logic [STATE_W-1:0] S_LOADS = 5'b00100;
  localparam logic [STATE_W-1:0] S_DONE  = 5'b01000;
  localparam logic [STATE_W-1:0] S_ERR   = 5'b10000;

  logic [STATE_W-1:0] state, state_nxt;
  logic [POS_W-1:0]   row, col;
  logic [CNT_W-1:0]   cnt;
  logic               accept, bad_p, bad_s, mismatch, last_cell, write_ok;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; illegal encodings recover to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_LOADP;
      S_LOADP: if (accept) begin
                 if (bad_p)          state_nxt = S_ERR;
                 else if (last_cell) state_nxt = S_LOADS;
               end
      S_LOADS: if (accept) begin
                 if (bad_s || mismatch) state_nxt = S_ERR;
                 else if (last_cell)    state_nxt = S_DONE;
               end
      S_DONE,
      S_ERR:   if (Ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    in_ready  = (state == S_LOADP) || (state == S_LOADS);
    accept    = in_valid && in_ready;
    bad_p     = in_digit > DIGIT_W'(MAX_DIGIT);
    bad_s     = (in_digit == '0) || (in_digit > DIGIT_W'(MAX_DIGIT));
    last_cell = cnt == CNT_W'(CELLS - 1);
    write_ok  = accept && (((state == S_LOADP) && !bad_p) ||
                           ((state == S_LOADS) && !bad_s && !mismatch));
    {q_Err, q_Done, q_LoadS, q_LoadP, q_Idle} = state;
    cell_count = cnt;
  end

  // Cursor, counter, error code and registered write port
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row      <= '0;
      col      <= '0;
      cnt      <= '0;
      err_code <= '0;
      wr_en    <= 1'b0;
      wr_sel   <= 1'b0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if ((state == S_IDLE) && Start) begin
        row      <= '0;
        col      <= '0;
        cnt      <= '0;
        err_code <= '0;
      end
      if (accept && (state == S_LOADP) && bad_p) err_code <= 2'd1;
      if (accept && (state == S_LOADS)) begin
        if (bad_s)         err_code <= 2'd2;
        else if (mismatch) err_code <= 2'd3;
      end
      if (write_ok) begin
        wr_en   <= 1'b1;
        wr_sel  <= (state == S_LOADS);
        wr_row  <= row;
        wr_col  <= col;
        wr_data <= in_digit;
        if (last_cell) begin
          // Puzzle phase restarts the count; solution phase leaves it full
          row <= '0;
          col <= '0;
          cnt <= (state == S_LOADP) ? '0 : cnt + CNT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (col == POS_W'(GRID_N - 1)) begin
            col <= '0;
            row <= row + POS_W'(1);
          end else begin
            col <= col + POS_W'(1);
          end
        end
      end
    end
  end

`ifdef SINDOKU_LOADER_CONSISTENCY_EN
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  logic [DIGIT_W-1:0] given [CELLS];
  logic [DIGIT_W-1:0] given_rd;

  // Record puzzle givens; cell index equals the in-phase count
  always_ff @(posedge Clk) begin
    if (write_ok && (state == S_LOADP)) given[IDX_W'(cnt)] <= in_digit;
  end

  assign given_rd = given[IDX_W'(cnt)];
  assign mismatch = (state == S_LOADS) && (given_rd != '0) && (in_digit != given_rd);
`else
  assign mismatch = 1'b0;
`endif

endmodule
